// File: rtl/pipe_trace_gen.sv
// Shadow 4-stage pipeline that tags fetched instructions and emits a retire-trace record stream
// through a small FIFO. Define TRACE_CYCLE_EN to build the fetch/retire cycle-stamp logic.
module pipe_trace_gen #(
  parameter int unsigned TAG_W = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic [15:0]      if_pc_i,
  input  logic [15:0]      if_instr_i,
  input  logic             trc_ready_i,
  output logic             trc_valid_o,
  output logic [TAG_W-1:0] trc_tag_o,
  output logic [15:0]      trc_pc_o,
  output logic [15:0]      trc_instr_o,
  output logic [15:0]      trc_fetch_cycle_o,
  output logic [15:0]      trc_retire_cycle_o,
  output logic             trc_overflow_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [15:0]      pc;
    logic [15:0]      instr;
  } slot_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [15:0]      pc;
    logic [15:0]      instr;
  } rec_t;

  slot_t ifid_q, ifid_d, idex_q, idex_d, exmem_q, exmem_d, memwb_q, memwb_d;
  logic [TAG_W-1:0] next_tag_q, next_tag_d;

  rec_t            mem_q [DEPTH];
  rec_t            head;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            full, push, pop, wr_en;

  always_comb begin
    ifid_d     = ifid_q;
    next_tag_d = next_tag_q;
    // Stall wins over flush: the held IF/ID entry is kept valid as-is.
    if (!stall_i) begin
      ifid_d.valid = !flush_i;
      ifid_d.tag   = next_tag_q;
      ifid_d.pc    = if_pc_i;
      ifid_d.instr = if_instr_i;
      next_tag_d   = next_tag_q + 1'b1;
    end
    idex_d = ifid_q;
    if (stall_i) begin
      idex_d.valid = 1'b0;
    end
    exmem_d = idex_q;
    memwb_d = exmem_q;
  end

  always_comb begin
    full        = (count_q == CntW'(DEPTH));
    trc_valid_o = (count_q != '0);
    push        = memwb_q.valid;
    pop         = trc_valid_o && trc_ready_i;
    // A pop on the same edge frees the slot the push needs.
    wr_en       = push && (!full || pop);
    wr_ptr_d    = wr_ptr_q + PtrW'(wr_en);
    rd_ptr_d    = rd_ptr_q + PtrW'(pop);
    count_d     = count_q + CntW'(wr_en) - CntW'(pop);
    overflow_d  = overflow_q | (push && full && !pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ifid_q     <= '0;
      idex_q     <= '0;
      exmem_q    <= '0;
      memwb_q    <= '0;
      next_tag_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      ifid_q     <= ifid_d;
      idex_q     <= idex_d;
      exmem_q    <= exmem_d;
      memwb_q    <= memwb_d;
      next_tag_q <= next_tag_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= '{tag: memwb_q.tag, pc: memwb_q.pc, instr: memwb_q.instr};
    end
  end

  // Storage is not reset, so data outputs are forced to zero while the FIFO is empty.
  always_comb begin
    head = trc_valid_o ? mem_q[rd_ptr_q] : '0;
  end

  assign trc_tag_o      = head.tag;
  assign trc_pc_o       = head.pc;
  assign trc_instr_o    = head.instr;
  assign trc_overflow_o = overflow_q;

`ifdef TRACE_CYCLE_EN
  logic [15:0] cycle_q;
  logic [15:0] ifid_cyc_q, idex_cyc_q, exmem_cyc_q, memwb_cyc_q;
  logic [15:0] fcyc_mem_q [DEPTH];
  logic [15:0] rcyc_mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_q     <= '0;
      ifid_cyc_q  <= '0;
      idex_cyc_q  <= '0;
      exmem_cyc_q <= '0;
      memwb_cyc_q <= '0;
    end else begin
      cycle_q     <= cycle_q + 16'd1;
      if (!stall_i) begin
        ifid_cyc_q <= cycle_q;
      end
      idex_cyc_q  <= ifid_cyc_q;
      exmem_cyc_q <= idex_cyc_q;
      memwb_cyc_q <= exmem_cyc_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      fcyc_mem_q[wr_ptr_q] <= memwb_cyc_q;
      rcyc_mem_q[wr_ptr_q] <= cycle_q;
    end
  end

  assign trc_fetch_cycle_o  = trc_valid_o ? fcyc_mem_q[rd_ptr_q] : '0;
  assign trc_retire_cycle_o = trc_valid_o ? rcyc_mem_q[rd_ptr_q] : '0;
`else
  assign trc_fetch_cycle_o  = '0;
  assign trc_retire_cycle_o = '0;
`endif

endmodule

// File: doc/pipe_trace_gen.md
PIPE_TRACE_GEN -- requirements
Module: pipe_trace_gen

Interface
REQ-001 Parameter TAG_W, default 8: width of the per-instruction sequence tag.
REQ-002 Parameter DEPTH, default 4: number of entries in the retire-record FIFO, power of two, at least 2.
REQ-003 clk  input  1: single clock; all state updates on posedge clk.
REQ-004 rst  input  1: synchronous, active-high reset.
REQ-005 stall  input  1: hazard stall; holds PC and IF/ID, inserts a bubble into ID/EX.
REQ-006 flush  input  1: taken-branch flush; the instruction fetched this cycle is squashed.
REQ-007 if_pc  input  16: PC of the instruction fetched this cycle.
REQ-008 if_instr  input  16: instruction word fetched this cycle.
REQ-009 trc_ready  input  1: consumer accepts the head record.
REQ-010 trc_valid  output  1: head record valid.
REQ-011 trc_tag  output  TAG_W: sequence tag of the retired instruction.
REQ-012 trc_pc, trc_instr  output  16 each: PC and instruction word captured at fetch.
REQ-013 trc_fetch_cycle, trc_retire_cycle  output  16 each: cycle-counter values at fetch and at retire.
REQ-014 trc_overflow  output  1: sticky flag; a retire record was dropped.

Function
REQ-015 Shadow pipeline of 4 slots (IF/ID, ID/EX, EX/MEM, MEM/WB); each slot holds valid, tag, pc, instr and fetch_cycle.
REQ-016 Free-running 16-bit cycle counter increments every non-reset edge; value 0 at the first edge after rst deasserts; wraps 0xFFFF to 0.
REQ-017 Fetch, when !stall: IF/ID loads {valid = !flush, next_tag, if_pc, if_instr, cycle}, and next_tag increments modulo 2^TAG_W.
REQ-018 A flushed fetch still consumes its tag, so the retire stream shows a gap.
REQ-019 When stall: IF/ID and next_tag hold, ID/EX loads valid=0, and flush is ignored (stall has priority).
REQ-020 ID/EX to EX/MEM to MEM/WB advance unconditionally every edge.
REQ-021 Unstalled latency: a fetch sampled at edge k is pushed at edge k+4 with retire_cycle = fetch_cycle + 4.
REQ-022 Push at each edge where MEM/WB.valid=1; the record is {tag, pc, instr, fetch_cycle, cycle}.
REQ-023 trc_valid = FIFO non-empty; a pop occurs at each edge where trc_valid && trc_ready.
REQ-024 Head record outputs are stable while trc_valid && !trc_ready.
REQ-025 Records are delivered in push order, with no duplication.
REQ-026 Push when full without a same-edge pop: record dropped, trc_overflow set.
REQ-027 Push when full with a same-edge pop: both occur, no drop.
REQ-028 Pointers wrap modulo DEPTH; a log2(DEPTH)+1-bit occupancy count distinguishes full from empty.

Reset
REQ-029 At rst: all slot valids clear, next_tag=0, cycle counter=0, FIFO empty, trc_valid=0, trc_overflow=0, and all data outputs read 0.
REQ-030 rst asserted mid-operation discards all in-flight and buffered records in that edge; there are no partial pops.
REQ-031 trc_overflow clears only on rst.

Configuration
REQ-032 Macro TRACE_CYCLE_EN defined: cycle counter and the fetch_cycle/retire_cycle storage are built as above.
REQ-033 TRACE_CYCLE_EN undefined: no counter or cycle storage is built; trc_fetch_cycle and trc_retire_cycle are constant 0; all other behaviour is identical.

Verification
REQ-034 Reset, then stall=flush=0, trc_ready=1, 8 edges -> records tags 0,1,2,3 with fetch_cycle 0..3 and retire_cycle 4..7; pc/instr match fetch inputs.
REQ-035 stall=1 at cycle 2 only -> tags remain 0,1,2,... with no gap; tag 1 retire_cycle 6 instead of 5; each later tag shifted by +1.
REQ-036 flush=1 at cycle 3 -> stream 0,1,2,4,5; tag 3 is never emitted; flush together with stall at cycle 5 -> no tag skipped.
REQ-037 trc_ready=0 for 12 cycles, DEPTH=4 -> trc_valid high, head tag 0 held stable, trc_overflow=1; after trc_ready=1, tags 0,1,2,3 are emitted in order, then the stream resumes.
REQ-038 300 unstalled fetches -> tag 255 is followed by tag 0; retire_cycle - fetch_cycle = 4 throughout.
REQ-039 rst pulsed with FIFO full and overflow set -> next cycle trc_valid=0, trc_overflow=0; first new record is tag 0 with fetch_cycle 0.
